// File: rtl/patseq_pkg.sv
// Shared constants, pointer types, FSM state encodings and the field clamp for
// the pattern sequencer.
package patseq_pkg;

  localparam int BUF_W       = 8;
  localparam int NO_BUFS     = 8;
  localparam int BUF_SIZE    = 32;
  localparam int SCRATCH     = 2;
  localparam int MAX_FIELD   = BUF_SIZE - SCRATCH - 1;
  localparam int BUF_IDX_W   = $clog2(NO_BUFS);
  localparam int FIELD_IDX_W = $clog2(BUF_SIZE);

  typedef logic [BUF_IDX_W-1:0]   buf_idx_t;
  typedef logic [FIELD_IDX_W-1:0] field_idx_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // The scratch bytes at the top of a buffer are never sequenced.
  function automatic field_idx_t clamp_field(input field_idx_t f);
    field_idx_t lim;
    lim = field_idx_t'(MAX_FIELD);
    if (f > lim) begin
      return lim;
    end else begin
      return f;
    end
  endfunction

endpackage

// File: rtl/patseq_outreg.sv
// One-deep valid/ready output register: captures on request, holds under
// backpressure, clears on a handshake with no new capture.
module patseq_outreg
  import patseq_pkg::*;
#(
  parameter int W = BUF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         slot_free
);

  assign slot_free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (capture) begin
      data  <= din;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Walks a programmed run of pattern buffers field by field, streams each byte
// out, and grants serial-load access only at buffer boundaries.
// Optional build macro: PATSEQ_CONTINUOUS_EN (repeat_cnt=8'hFF repeats forever).
module pattern_sequencer
  import patseq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       first_buf,
  input  logic [2:0]       seq_len,
  input  logic [4:0]       last_field,
  input  logic [7:0]       repeat_cnt,
  input  logic [BUF_W-1:0] field_byte,
  output logic [2:0]       bufp,
  output logic [4:0]       fieldp,
  output logic [BUF_W-1:0] pat_data,
  output logic             pat_valid,
  input  logic             pat_ready,
  input  logic             load_req,
  output logic             load_gnt,
  output logic             busy,
  output logic             done
);

  logic [1:0] state, state_n;
  buf_idx_t   first_r, first_n;
  buf_idx_t   len_r, len_n;
  field_idx_t last_r, last_n;
  logic [7:0] rep_r, rep_n;
  logic [7:0] pass_cnt, pass_n;
  buf_idx_t   buf_cnt, bcnt_n;
  buf_idx_t   bufp_n;
  field_idx_t fieldp_n;
  logic       gnt_n;
  logic       done_n;
  logic       capture;
  logic       slot_free;
  logic       run_forever;

`ifdef PATSEQ_CONTINUOUS_EN
  assign run_forever = (rep_r == 8'hFF);
`else
  assign run_forever = 1'b0;
`endif

  patseq_outreg #(.W(BUF_W)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .din       (field_byte),
    .ready     (pat_ready),
    .data      (pat_data),
    .valid     (pat_valid),
    .slot_free (slot_free)
  );

  always_comb begin
    state_n  = state;
    first_n  = first_r;
    len_n    = len_r;
    last_n   = last_r;
    rep_n    = rep_r;
    pass_n   = pass_cnt;
    bcnt_n   = buf_cnt;
    bufp_n   = bufp;
    fieldp_n = fieldp;
    gnt_n    = load_gnt;
    done_n   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = load_req;
        if (start && !load_req) begin
          first_n  = first_buf;
          len_n    = seq_len;
          last_n   = clamp_field(last_field);
          rep_n    = repeat_cnt;
          bufp_n   = first_buf;
          fieldp_n = 5'd0;
          pass_n   = 8'd0;
          bcnt_n   = 3'd0;
          state_n  = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = DRAIN;
          gnt_n   = 1'b0;
        end else if (slot_free) begin
          capture = 1'b1;
          if (fieldp < last_r) begin
            fieldp_n = fieldp + 5'd1;
          end else begin
            fieldp_n = 5'd0;
            if (buf_cnt < len_r) begin
              bufp_n = bufp + 3'd1;
              bcnt_n = buf_cnt + 3'd1;
            end else if (run_forever || (pass_cnt < rep_r)) begin
              bufp_n = first_r;
              bcnt_n = 3'd0;
              pass_n = run_forever ? pass_cnt : (pass_cnt + 8'd1);
            end else begin
              state_n = DRAIN;
            end
            // The pointer step above still happens, so PAUSE resumes at the next buffer.
            if (load_req && (state_n != DRAIN)) begin
              state_n = PAUSE;
              gnt_n   = 1'b1;
            end else begin
              gnt_n = load_gnt;
            end
          end
        end else begin
          state_n = RUN;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n = DRAIN;
          gnt_n   = 1'b0;
        end else if (!load_req) begin
          state_n = RUN;
          gnt_n   = 1'b0;
        end else begin
          state_n = PAUSE;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      first_r  <= 3'd0;
      len_r    <= 3'd0;
      last_r   <= 5'd0;
      rep_r    <= 8'd0;
      pass_cnt <= 8'd0;
      buf_cnt  <= 3'd0;
      bufp     <= 3'd0;
      fieldp   <= 5'd0;
      load_gnt <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      first_r  <= first_n;
      len_r    <= len_n;
      last_r   <= last_n;
      rep_r    <= rep_n;
      pass_cnt <= pass_n;
      buf_cnt  <= bcnt_n;
      bufp     <= bufp_n;
      fieldp   <= fieldp_n;
      load_gnt <= gnt_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer; the store is modelled as
// field_byte = {bufp, fieldp} so every byte names its own address.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [2:0] first_buf;
  logic [2:0] seq_len;
  logic [4:0] last_field;
  logic [7:0] repeat_cnt;
  logic [7:0] field_byte;
  logic [2:0] bufp;
  logic [4:0] fieldp;
  logic [7:0] pat_data;
  logic       pat_valid;
  logic       pat_ready;
  logic       load_req;
  logic       load_gnt;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  assign field_byte = {bufp, fieldp};

  pattern_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .first_buf(first_buf), .seq_len(seq_len), .last_field(last_field),
    .repeat_cnt(repeat_cnt), .field_byte(field_byte), .bufp(bufp),
    .fieldp(fieldp), .pat_data(pat_data), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .load_req(load_req), .load_gnt(load_gnt),
    .busy(busy), .done(done)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int cyc, last_acc, done_cnt, done_cyc, max_field;

  task automatic clear_acc();
    got.delete();
    exp_q.delete();
    cyc = 0; last_acc = -1; done_cnt = 0; done_cyc = -1; max_field = 0;
  endtask

  // Advance to the next falling edge, set ready, then record what the next rising edge accepts.
  task automatic step(input logic rdy);
    @(negedge clk);
    pat_ready = rdy;
    cyc++;
    if (pat_valid && pat_ready) begin
      got.push_back(pat_data);
      last_acc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(fieldp) > max_field) max_field = int'(fieldp);
  endtask

  task automatic kick(input logic [2:0] fb, input logic [2:0] sl, input logic [4:0] lf, input logic [7:0] rc);
    @(negedge clk);
    first_buf = fb; seq_len = sl; last_field = lf; repeat_cnt = rc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_exp(input logic [2:0] fb, input int sl, input int lf, input int rc);
    int lim;
    logic [2:0] bb;
    logic [4:0] ff;
    lim = (lf > 29) ? 29 : lf;
    for (int p = 0; p <= rc; p++)
      for (int b = 0; b <= sl; b++)
        for (int f = 0; f <= lim; f++) begin
          bb = fb + 3'(b);
          ff = 5'(f);
          exp_q.push_back({bb, ff});
        end
  endtask

  function automatic int mismatches();
    int m;
    m = (got.size() > exp_q.size()) ? (got.size() - exp_q.size()) : (exp_q.size() - got.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step(1'b1);
    step(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; first_buf = 3'd0; seq_len = 3'd0;
    last_field = 5'd0; repeat_cnt = 8'd0; pat_ready = 1'b0; load_req = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bufp, fieldp, pat_data, pat_valid, load_gnt, busy, done} !== 21'd0)
      $display("FAIL reset_outputs: got %h expected 0", {bufp, fieldp, pat_data, pat_valid, load_gnt, busy, done});
    else n_pass++;
    rst = 1'b0;
    load_req = 1'b1;
    kick(3'd0, 3'd0, 5'd3, 8'd0);
    step(1'b1);
    n_total++;
    if ({busy, load_gnt} !== 2'b01) $display("FAIL idle_grant: busy,gnt=%b expected 01", {busy, load_gnt});
    else n_pass++;
    load_req = 1'b0;
    step(1'b1);
    n_total++;
    if (load_gnt !== 1'b0) $display("FAIL idle_release: gnt=%b expected 0", load_gnt);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] hand[8] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h60, 8'h61, 8'h62, 8'h63};
    clear_acc();
    foreach (hand[i]) exp_q.push_back(hand[i]);
    kick(3'd2, 3'd1, 5'd3, 8'd0);
    run_to_done(40);
    n_total++;
    if (got.size() !== 8) $display("FAIL basic_count: got %0d expected 8", got.size()); else n_pass++;
    n_total++;
    if (mismatches() !== 0) $display("FAIL basic_data: %0d mismatching bytes expected 0", mismatches()); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
    n_total++;
    if (done_cyc !== last_acc + 1) $display("FAIL basic_done_time: cycle %0d expected %0d", done_cyc, last_acc + 1); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_wrap_repeat();
    logic [7:0] hand[6] = '{8'hE0, 8'h00, 8'hE0, 8'h00, 8'hE0, 8'h00};
    clear_acc();
    foreach (hand[i]) exp_q.push_back(hand[i]);
    kick(3'd7, 3'd1, 5'd0, 8'd2);
    run_to_done(40);
    n_total++;
    if (got.size() !== 6) $display("FAIL wrap_count: got %0d expected 6", got.size()); else n_pass++;
    n_total++;
    if (mismatches() !== 0) $display("FAIL wrap_data: %0d mismatching bytes expected 0", mismatches()); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL wrap_done: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] snap;
    int errs;
    clear_acc();
    build_exp(3'd0, 0, 7, 0);
    kick(3'd0, 3'd0, 5'd7, 8'd0);
    repeat (3) step(1'b1);
    step(1'b0);
    snap = {pat_data, pat_valid, bufp, fieldp[3:0]};
    errs = 0;
    repeat (4) begin
      step(1'b0);
      if ({pat_data, pat_valid, bufp, fieldp[3:0]} !== snap) errs++;
    end
    run_to_done(40);
    n_total++;
    if (snap[7] !== 1'b1) $display("FAIL bp_valid_held: got %b expected 1", snap[7]); else n_pass++;
    n_total++;
    if (errs !== 0) $display("FAIL bp_hold: %0d changed cycles expected 0", errs); else n_pass++;
    n_total++;
    if (mismatches() !== 0) $display("FAIL bp_data: %0d mismatching bytes expected 0", mismatches()); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL bp_done: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_load_arb();
    int errs;
    clear_acc();
    build_exp(3'd1, 1, 3, 0);
    kick(3'd1, 3'd1, 5'd3, 8'd0);
    for (int i = 0; i < 20 && !(bufp == 3'd1 && fieldp == 5'd1); i++) step(1'b1);
    load_req = 1'b1;
    for (int i = 0; i < 20 && load_gnt !== 1'b1; i++) step(1'b1);
    n_total++;
    if (load_gnt !== 1'b1) $display("FAIL load_gnt_rise: got %b expected 1", load_gnt); else n_pass++;
    n_total++;
    if (pat_data !== 8'h23) $display("FAIL load_last_byte: got %h expected 23", pat_data); else n_pass++;
    n_total++;
    if ({bufp, fieldp} !== 8'h40) $display("FAIL load_ptr: got %h expected 40", {bufp, fieldp}); else n_pass++;
    errs = 0;
    repeat (4) begin
      step(1'b1);
      if ({bufp, fieldp, pat_valid, load_gnt} !== 10'b0100000001) errs++;
    end
    n_total++;
    if (errs !== 0 || got.size() !== 4) $display("FAIL load_frozen: %0d bad cycles, %0d bytes expected 0 and 4", errs, got.size()); else n_pass++;
    load_req = 1'b0;
    step(1'b1);
    n_total++;
    if (load_gnt !== 1'b0) $display("FAIL load_release: got %b expected 0", load_gnt); else n_pass++;
    run_to_done(40);
    n_total++;
    if (mismatches() !== 0) $display("FAIL load_data: %0d mismatching bytes expected 0", mismatches()); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL load_done: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_abort_reset();
    clear_acc();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    kick(3'd0, 3'd1, 5'd9, 8'd0);
    for (int i = 0; i < 20 && got.size() < 3; i++) step(1'b1);
    stop = 1'b1;
    step(1'b1);
    stop = 1'b0;
    run_to_done(20);
    n_total++;
    if (mismatches() !== 0) $display("FAIL abort_data: %0d mismatching bytes (%0d received) expected 0", mismatches(), got.size()); else n_pass++;
    n_total++;
    if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL abort_done: done %0d busy %b expected 1 and 0", done_cnt, busy); else n_pass++;

    clear_acc();
    kick(3'd0, 3'd0, 5'd20, 8'd0);
    for (int i = 0; i < 20 && got.size() < 2; i++) step(1'b1);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({bufp, fieldp, pat_data, pat_valid, load_gnt, busy} !== 20'd0)
      $display("FAIL rst_mid_run: got %h expected 0", {bufp, fieldp, pat_data, pat_valid, load_gnt, busy});
    else n_pass++;
    repeat (3) step(1'b1);
    rst = 1'b0;
    repeat (4) step(1'b1);
    n_total++;
    if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL rst_no_done: done %0d busy %b expected 0 and 0", done_cnt, busy); else n_pass++;
  endtask

  task automatic test_clamp_continuous();
    clear_acc();
    build_exp(3'd5, 0, 31, 0);
    kick(3'd5, 3'd0, 5'd31, 8'd0);
    run_to_done(80);
    n_total++;
    if (max_field !== 29) $display("FAIL clamp_max_field: got %0d expected 29", max_field); else n_pass++;
    n_total++;
    if (got.size() !== 30 || mismatches() !== 0) $display("FAIL clamp_data: %0d bytes %0d mismatches expected 30 and 0", got.size(), mismatches()); else n_pass++;

    clear_acc();
    kick(3'd0, 3'd0, 5'd0, 8'hFF);
`ifdef PATSEQ_CONTINUOUS_EN
    repeat (320) step(1'b1);
    n_total++;
    if (got.size() <= 300 || done_cnt !== 0) $display("FAIL cont_forever: %0d passes done %0d expected >300 and 0", got.size(), done_cnt); else n_pass++;
    stop = 1'b1;
    step(1'b1);
    stop = 1'b0;
    run_to_done(20);
    n_total++;
    if (done_cnt !== 1) $display("FAIL cont_stop_done: got %0d expected 1", done_cnt); else n_pass++;
`else
    run_to_done(400);
    n_total++;
    if (got.size() !== 256) $display("FAIL ff_count: got %0d passes expected 256", got.size()); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL ff_done: got %0d expected 1", done_cnt); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_repeat();
    test_backpressure();
    test_load_arb();
    test_abort_reset();
    test_clamp_continuous();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Controller for the 8-buffer pattern store: drives `bufp`/`fieldp` to walk a programmed run of buffers field by field.
- Registers each addressed `field_byte` into a valid/ready output stream.
- Arbitrates serial-load access: the host requests the store, and the sequencer grants it only at a buffer boundary, so a buffer is never rewritten mid-read.

Parameters:
- BUF_W, 8, pattern byte width in bits.
- NO_BUFS, 8, number of pattern buffers; `bufp` width is log2(NO_BUFS).
- BUF_SIZE, 32, bytes per buffer; `fieldp` width is log2(BUF_SIZE).
- SCRATCH, 2, top bytes of each buffer reserved as scratch and never sequenced.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sequence from IDLE, ignored in other states.
- stop  in  1  level; aborts the sequence at the next edge.
- first_buf  in  3  first buffer index of the sequence.
- seq_len  in  3  number of buffers in one pass, minus 1.
- last_field  in  5  last field index per buffer; clamped to BUF_SIZE-SCRATCH-1 (29).
- repeat_cnt  in  8  extra passes after the first.
- field_byte  in  BUF_W  byte at (bufp, fieldp), combinational from the store.
- bufp  out  3  buffer select.
- fieldp  out  5  field select.
- pat_data  out  BUF_W  output pattern byte.
- pat_valid  out  1  pat_data holds a valid byte.
- pat_ready  in  1  consumer accepts the byte.
- load_req  in  1  host requests the serial-load path.
- load_gnt  out  1  store is free for serial load.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the sequence ends.

Behaviour:
- Reset values: state IDLE, bufp=0, fieldp=0, pat_data=0, pat_valid=0, load_gnt=0, busy=0, done=0, internal counters=0.
- Reset asserted mid-sequence: everything returns to reset values at once and no done pulse is produced.
- Slot rule: the output register is free when `!pat_valid || pat_ready`.
- Capture timing: `field_byte` for the current bufp/fieldp is captured on the same edge the pointers advance, so the first byte appears one cycle after RUN is entered.

States:
- IDLE: load_gnt = load_req (direct grant, registered).
  - On start with no load_req active: latch first_buf, seq_len, clamped last_field and repeat_cnt; set bufp=first_buf, fieldp=0, pass counter=0, buffer counter=0; go to RUN.
  - start while load_req is active is ignored.
- RUN, on each edge where the slot is free:
  - pat_data<=field_byte, pat_valid<=1.
  - If fieldp<last_field: fieldp+1.
  - Otherwise (buffer boundary): fieldp<=0.
    - If buffer counter<seq_len: bufp+1, wrapping 7 to 0, and buffer counter+1.
    - Else if pass counter<repeat_cnt: bufp<=first_buf, buffer counter=0, pass counter+1.
    - Else go to DRAIN.
  - When the slot is not free, hold everything.
- RUN to PAUSE: when load_req is high on a boundary-advance edge and the sequence is not ending. load_gnt<=1 on that edge.
- PAUSE: pointers frozen; pat_valid still clears on pat_ready. When load_req falls: load_gnt<=0 and return to RUN next cycle.
- DRAIN: no further captures. When pat_valid=0 (or on the handshake that clears it): pulse done, go to IDLE.
- stop in RUN or PAUSE: go to DRAIN next edge, no capture on that edge, load_gnt<=0. stop has priority over load_req and over the boundary step.
- pat_valid clears only on pat_ready with no new capture; pat_data stays stable while `pat_valid && !pat_ready`.
- bufp wrap-around is modulo NO_BUFS (e.g. first_buf=6, seq_len=3 gives 6,7,0,1).

Optional Feature:
- Macro: PATSEQ_CONTINUOUS_EN.
- When defined: repeat_cnt=8'hFF means repeat forever; the pass counter never ends the sequence, and only stop or rst terminates it.
- When undefined: 8'hFF is a plain count of 255 extra passes.

Decomposition:
- Package `patseq_pkg`:
  - state enum {IDLE, RUN, PAUSE, DRAIN};
  - constants BUF_W, NO_BUFS, BUF_SIZE, SCRATCH, MAX_FIELD=BUF_SIZE-SCRATCH-1;
  - ptr typedefs buf_idx_t (3b) and field_idx_t (5b).
- One natural sub-module, `patseq_outreg`: the one-deep valid/ready output register (capture, hold, clear).

Test Plan:
- Basic run: first_buf=2, seq_len=1, last_field=3, repeat_cnt=0, pat_ready=1 -> 8 bytes from (2,0..3) then (3,0..3), done pulse 1 cycle after the last byte is accepted, then busy=0.
- Wrap and repeat: first_buf=7, seq_len=1, last_field=0, repeat_cnt=2 -> bufp sequence 7,0,7,0,7,0 and 6 bytes out.
- Backpressure: pat_ready low for 5 cycles mid-buffer -> pat_data/pat_valid and pointers held, no byte lost or duplicated.
- Load arbitration: load_req raised at field 1 of a buffer with last_field=3 -> load_gnt rises only after field 3 is captured, pointers frozen; load_req dropped -> resumes at field 0 of the next buffer.
- Abort and reset: stop mid-buffer -> no further captures, done after drain; rst mid-RUN -> all outputs zero immediately and no done pulse.
- Clamp and continuous: last_field=31 -> fieldp never exceeds 29. With PATSEQ_CONTINUOUS_EN and repeat_cnt=FF -> more than 300 passes with no done, until stop.
